// File: rtl/eff_ctrl_if.sv
// Footswitch / sample-strobe inputs and enable / mute outputs of the effect enable controller.
// The controller takes the slave side; the board or bench takes the master side.
interface eff_ctrl_if #(
    parameter int NUM_EFF = 4
);
    logic [NUM_EFF-1:0] btn_i;
    logic               vld_i;
    logic [NUM_EFF-1:0] en_o;
    logic               mute_o;
    logic               busy_o;

    modport master (
        output btn_i,
        output vld_i,
        input  en_o,
        input  mute_o,
        input  busy_o
    );

    modport slave (
        input  btn_i,
        input  vld_i,
        output en_o,
        output mute_o,
        output busy_o
    );
endinterface

// File: rtl/eff_ctrl.sv
// Footswitch enable controller: sync + debounce per switch, toggles en_o only inside a vld_i-aligned mute window.
// Press to mute_o is DEBOUNCE_CYCLES+3 clocks; no backpressure, the window simply waits for vld_i pulses.
module eff_ctrl #(
    parameter int NUM_EFF         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MUTE_SAMPLES    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    eff_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(MUTE_SAMPLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] MS_LAST = SW'(MUTE_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUTE   = 2'd1,
        SWITCH = 2'd2,
        UNMUTE = 2'd3
    } state_t;

    logic [NUM_EFF-1:0] sync1;
    logic [NUM_EFF-1:0] sync2;
    logic [NUM_EFF-1:0] db_lvl;
    logic [DW-1:0]      db_cnt [NUM_EFF];
    logic [NUM_EFF-1:0] press;
    logic [NUM_EFF-1:0] pending;
    logic [NUM_EFF-1:0] applied;

    state_t             state;
    state_t             state_nx;
    logic [SW-1:0]      scnt;
    logic [SW-1:0]      scnt_nx;
    logic [NUM_EFF-1:0] en;
    logic [NUM_EFF-1:0] en_nx;
    logic               mute;
    logic               busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_i;
            sync2 <= sync1;
        end
    end

    // A level is accepted after it has differed from the debounced value for DEBOUNCE_CYCLES+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl <= '0;
            for (int i = 0; i < NUM_EFF; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EFF; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < NUM_EFF; i++) begin
            press[i] = sync2[i] & ~db_lvl[i] & (db_cnt[i] == DB_LAST);
        end
    end

    assign applied = (state == SWITCH) ? pending : '0;

    // XOR lets a second press cancel an unapplied request, and re-arms a bit applied in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~applied) ^ press;
        end
    end

    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        en_nx    = en;
        case (state)
            IDLE: begin
                scnt_nx = '0;
                if (|pending) begin
                    state_nx = MUTE;
                end
            end
            MUTE: begin
                if (bus.vld_i) begin
                    if (scnt == MS_LAST) begin
                        scnt_nx  = '0;
                        state_nx = SWITCH;
                    end else begin
                        scnt_nx = scnt + 1'b1;
                    end
                end
            end
            SWITCH: begin
                en_nx    = en ^ pending;
                scnt_nx  = '0;
                state_nx = UNMUTE;
            end
            UNMUTE: begin
                if (bus.vld_i) begin
                    if (scnt == MS_LAST) begin
                        scnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        scnt_nx = scnt + 1'b1;
                    end
                end
            end
            default: begin
                scnt_nx  = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            scnt  <= '0;
            en    <= '0;
            mute  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            scnt  <= scnt_nx;
            en    <= en_nx;
            mute  <= (state_nx != IDLE);
            busy  <= (state_nx != IDLE);
        end
    end

    assign bus.en_o   = en;
    assign bus.mute_o = mute;
    assign bus.busy_o = busy;
endmodule

// File: tb/tb_eff_ctrl.sv
// Randomised and directed bench for eff_ctrl with a per-cycle reference model and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_eff_ctrl;
    localparam int N = 4;
    localparam int D = 8;
    localparam int M = 2;

    typedef struct packed {
        logic [N-1:0] en;
        logic         mute;
        logic         busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eff_ctrl_if #(.NUM_EFF(N)) bus ();

    eff_ctrl #(
        .NUM_EFF(N),
        .DEBOUNCE_CYCLES(D),
        .MUTE_SAMPLES(M)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 0;
    int   cyc = 0;

    // Reference model: raw switch history, accepted levels, request set and window progress.
    logic [N-1:0] hist[$];
    logic [N-1:0] acc;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_en;
    int           stable_run[N];
    bit           win;
    bit           swdone;
    int           vc;

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got en=%b mute=%b busy=%b, want en=%b mute=%b busy=%b",
                     name, $time, got.en, got.mute, got.busy, want.en, want.mute, want.busy);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        acc    = '0;
        m_pend = '0;
        m_en   = '0;
        win    = 0;
        swdone = 0;
        vc     = 0;
        for (int i = 0; i < N; i++) stable_run[i] = 0;
    endtask

    // Advance the model across one clock edge given the inputs held before it.
    task automatic model_edge(input logic [N-1:0] b, input bit v);
        logic [N-1:0] seen;
        logic [N-1:0] ev;
        logic [N-1:0] applied;
        seen = hist.pop_front();
        hist.push_back(b);
        ev = '0;
        for (int i = 0; i < N; i++) begin
            if (seen[i] == acc[i]) begin
                stable_run[i] = 0;
            end else begin
                stable_run[i]++;
                if (stable_run[i] == D + 1) begin
                    ev[i]         = seen[i];
                    acc[i]        = seen[i];
                    stable_run[i] = 0;
                end
            end
        end
        applied = '0;
        if (!win) begin
            if (m_pend != '0) begin
                win = 1;
                vc  = 0;
            end
        end else if (vc == M && !swdone) begin
            applied = m_pend;
            m_en    = m_en ^ m_pend;
            swdone  = 1;
        end else if (v) begin
            vc++;
            if (vc == 2 * M) begin
                win    = 0;
                swdone = 0;
            end
        end
        m_pend = (m_pend & ~applied) ^ ev;
        exp_q.push_back({m_en, win, win});
    endtask

    task automatic step(input logic [N-1:0] b, input bit v);
        @(negedge clk);
        bus.btn_i = b;
        bus.vld_i = v;
        model_edge(b, v);
        cyc++;
    endtask

    // vmode: 0 = no samples, 1 = one pulse every 4 cycles, 2 = random pulses
    task automatic drive(input logic [N-1:0] b, input int n, input int vmode);
        for (int k = 0; k < n; k++) begin
            bit v;
            if (vmode == 0)      v = 0;
            else if (vmode == 1) v = (cyc % 4 == 0);
            else                 v = ($urandom_range(0, 3) == 0);
            step(b, v);
        end
    endtask

    task automatic reset_mid();
        obs_t g;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        g = {bus.en_o, bus.mute_o, bus.busy_o};
        check("async_reset", g, '0);
        mon_on = 0;
        exp_q.delete();
        model_reset();
        bus.btn_i = '0;
        bus.vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1;
    endtask

    obs_t mon_got;
    obs_t mon_want;
    always @(posedge clk) begin
        #1;
        if (mon_on && exp_q.size() > 0) begin
            mon_want = exp_q.pop_front();
            mon_got  = {bus.en_o, bus.mute_o, bus.busy_o};
            check("cycle", mon_got, mon_want);
        end
    end

    initial begin
        obs_t g;
        logic [N-1:0] rb;
        bus.btn_i = '0;
        bus.vld_i = 1'b0;
        model_reset();
        #3;
        g = {bus.en_o, bus.mute_o, bus.busy_o};
        check("reset_state", g, '0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1;

        // clean press, then the same press again to toggle back
        drive(4'b0001, 30, 1);
        drive(4'b0000, 30, 1);
        drive(4'b0001, 30, 1);
        drive(4'b0000, 30, 1);

        // bouncing switch never settles
        for (int k = 0; k < 20; k++) drive((k % 2 == 0) ? 4'b0000 : 4'b0010, 3, 1);
        drive(4'b0000, 20, 1);

        // two switches rising together
        drive(4'b0101, 30, 1);
        drive(4'b0000, 30, 1);

        // press/release twice while the window is stalled in MUTE cancels the request
        drive(4'b1000, 12, 0);
        drive(4'b0000, 12, 0);
        drive(4'b1000, 12, 0);
        drive(4'b0000, 12, 0);
        drive(4'b0000, 40, 1);

        // second press lands during UNMUTE of the first window
        drive(4'b0100, 14, 1);
        drive(4'b0110, 20, 1);
        drive(4'b0000, 40, 1);

        // sample strobe stalls for 200 cycles, then resumes
        drive(4'b0010, 200, 0);
        drive(4'b0000, 40, 1);

        // reset while in UNMUTE, then confirm nothing happens without a new press
        for (int k = 0; k < 200 && !(win && swdone); k++) drive(4'b0001, 1, 1);
        reset_mid();
        drive(4'b0000, 40, 1);

        // random switch activity with random sample timing
        rb = '0;
        for (int k = 0; k < 150; k++) begin
            rb[$urandom_range(0, N - 1)] ^= 1'b1;
            drive(rb, $urandom_range(1, 25), 2);
        end
        drive(4'b0000, 60, 1);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
